mem_capture_ctrl: RTL
=====================

# mem_capture_ctrl

Sequencer for the banked ADC capture memory in the capture/monitor path. Arms on request and aligns to the next ADC frame boundary. Then streams `NUM_BANKS*BANK_DEPTH` consecutive words into the banks in bank-major order. Finally it replays the same addresses to the `clk_mon`-side serializer through a valid/ready request port. Runs entirely in the `clk_in` domain; the serializer's CDC is outside this block.

## Interface
- `NUM_BANKS`, 4, number of memory banks (≥1)
- `BANK_DEPTH`, 1024, words per bank (power of two)
- `FRAME_LENGTH`, 64, ADC words per frame; `NUM_BANKS*BANK_DEPTH` must be a multiple of it (elaboration assertion)
- `clk_in`  in  1  capture clock
- `rst`  in  1  asynchronous, active-high reset
- `arm`  in  1  one-cycle start request; ignored unless in IDLE
- `abort`  in  1  return to IDLE from any state
- `in_valid`  in  1  ADC word present this cycle
- `frame_start`  in  1  qualifies the current `in_valid` word as the first word of a frame
- `wr_en`  out  1  bank write strobe
- `wr_bank`  out  $clog2(NUM_BANKS) (min 1)  write bank index
- `wr_addr`  out  $clog2(BANK_DEPTH)  write word address
- `rd_valid`  out  1  read request valid
- `rd_ready`  in  1  serializer accepts request
- `rd_bank`  out  $clog2(NUM_BANKS) (min 1)  read bank index
- `rd_addr`  out  $clog2(BANK_DEPTH)  read word address
- `rd_last`  out  1  current request is the final word
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after the final read handshake
- `frame_err`  out  1  sticky; set on a misaligned `frame_start` during CAPTURE; cleared by `arm` or `rst`

## Operation
- States:
  - IDLE: `arm` → ARMED.
  - ARMED: `in_valid && frame_start` → CAPTURE. That word is word 0 and is written.
  - CAPTURE: each `in_valid` writes one word. After word `NUM_BANKS*BANK_DEPTH-1` is written → READOUT.
  - READOUT: `rd_valid` held high. A handshake (`rd_valid && rd_ready`) advances the address. The handshake with `rd_last` → IDLE and pulses `done`.
- `abort` has priority over every transition → IDLE next cycle. Any pending write or request is dropped. No `done` pulse.
- Address order for both writes and reads: `addr` increments first; on wrap from `BANK_DEPTH-1` to 0, `bank` increments. Both counters clear on entering CAPTURE and on entering READOUT.
- Frame phase counter counts 0..FRAME_LENGTH-1 on each written word.
  - In CAPTURE, `frame_start` with phase ≠ 0 sets `frame_err`; capture continues unaltered.
  - Phase 0 without `frame_start` is not an error.
- `in_valid` outside CAPTURE/ARMED is ignored. `arm` while busy is ignored.
- `rd_bank`/`rd_addr`/`rd_last` hold stable while `rd_valid && !rd_ready`.

## Timing
- Reset values: state IDLE, all outputs 0.
- Write outputs are registered. `wr_en`/`wr_bank`/`wr_addr` appear 1 cycle after the `in_valid` cycle they describe. The datapath delays ADC data by one register to match.
- The ARMED→CAPTURE word is written: `wr_en` rises 1 cycle after the qualifying `frame_start`.
- The last write's `wr_en` and the first `rd_valid` are asserted in the same cycle. READOUT entry is 1 cycle after the last `in_valid`.
- `rd_valid` is registered. After a handshake, the next request is presented in the following cycle, giving one request per cycle with `rd_ready` held high. `rd_valid` drops the cycle after the `rd_last` handshake, the same cycle `done` pulses.
- `abort` and `arm` in the same cycle: abort wins; the block stays in IDLE.
- `rst` mid-capture: immediate async clear; memory contents are not guaranteed.

## Structure
- Shared `mem_ctrl_pkg`:
  - state enum `cap_state_e`
  - `BANK_W`/`ADDR_W` derivation functions
  - a `bank_addr_t` struct {bank, addr}
- One sub-module, `bank_addr_counter`: clear/increment/last flag, with the wrap rule above. It is instantiated twice, once for writes and once for reads.
- Top level holds the FSM, frame phase counter, and `frame_err`.

## Test plan
- NUM_BANKS=2, BANK_DEPTH=8, FRAME_LENGTH=4; `arm`, then continuous `in_valid` with `frame_start` every 4 words → exactly 16 writes (b0:a0..7, b1:a0..7), `frame_err`=0. Then 16 requests with `rd_ready`=1 at one per cycle, `rd_last` on b1:a7, one `done` pulse.
- Same configuration with `in_valid` toggling 50% → write addresses are still contiguous and no write occurs on idle cycles.
- ARMED held 5 cycles with `in_valid` but no `frame_start` → no writes; the first `frame_start` produces write b0:a0.
- `frame_start` injected at phase 2 during capture → `frame_err` rises and stays high; all 16 writes still complete. A subsequent `arm` clears `frame_err`.
- `rd_ready` stalled 3 cycles on request b0:a5 → `rd_bank`/`rd_addr` hold b0:a5; no address is skipped or duplicated.
- `abort` at write 10, and separately async `rst` mid-READOUT → IDLE, all outputs 0, no `done`. A following `arm` restarts capture at b0:a0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and width helpers for the banked capture-memory sequencer.
package mem_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_READOUT
  } cap_state_e;

  // Counter fields are carried at a fixed width; callers slice the low bits they need.
  typedef struct packed {
    logic [CNT_W-1:0] bank;
    logic [CNT_W-1:0] addr;
  } bank_addr_t;

  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int addr_w(input int bank_depth);
    return (bank_depth > 1) ? $clog2(bank_depth) : 1;
  endfunction

endpackage

// File: rtl/bank_addr_counter.sv
// Bank-major address walker: addr increments first, bank advances when addr wraps.
module bank_addr_counter
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 1024
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            inc,
  output logic [bank_w(NUM_BANKS)-1:0]    bank,
  output logic [addr_w(BANK_DEPTH)-1:0]   addr,
  output logic                            last
);

  localparam int BANK_W = bank_w(NUM_BANKS);
  localparam int ADDR_W = addr_w(BANK_DEPTH);
  localparam logic [CNT_W-1:0] ADDR_MAX = CNT_W'(BANK_DEPTH - 1);
  localparam logic [CNT_W-1:0] BANK_MAX = CNT_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  bank_addr_t cnt_q, cnt_d;
  logic       addr_wrap;

  assign addr_wrap = (cnt_q.addr == ADDR_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (addr_wrap) begin
        cnt_d.addr = '0;
        cnt_d.bank = (cnt_q.bank == BANK_MAX) ? '0 : cnt_q.bank + ONE;
      end else begin
        cnt_d.addr = cnt_q.addr + ONE;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bank = cnt_q.bank[BANK_W-1:0];
  assign addr = cnt_q.addr[ADDR_W-1:0];
  assign last = addr_wrap && (cnt_q.bank == BANK_MAX);

endmodule

// File: rtl/mem_capture_ctrl.sv
// Capture sequencer: arm, align to a frame start, fill all banks, then replay
// the same addresses as valid/ready read requests.
module mem_capture_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_BANKS    = 4,
  parameter int BANK_DEPTH   = 1024,
  parameter int FRAME_LENGTH = 64
) (
  input  logic                           clk_in,
  input  logic                           rst,
  input  logic                           arm,
  input  logic                           abort,
  input  logic                           in_valid,
  input  logic                           frame_start,
  output logic                           wr_en,
  output logic [bank_w(NUM_BANKS)-1:0]   wr_bank,
  output logic [addr_w(BANK_DEPTH)-1:0]  wr_addr,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [bank_w(NUM_BANKS)-1:0]   rd_bank,
  output logic [addr_w(BANK_DEPTH)-1:0]  rd_addr,
  output logic                           rd_last,
  output logic                           busy,
  output logic                           done,
  output logic                           frame_err
);

  localparam int BANK_W  = bank_w(NUM_BANKS);
  localparam int ADDR_W  = addr_w(BANK_DEPTH);
  localparam int PHASE_W = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(FRAME_LENGTH - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);

  if (((NUM_BANKS * BANK_DEPTH) % FRAME_LENGTH) != 0) begin : g_bad_frame_len
    $error("NUM_BANKS*BANK_DEPTH must be a multiple of FRAME_LENGTH");
  end
  if ((BANK_DEPTH & (BANK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BANK_DEPTH must be a power of two");
  end

  cap_state_e         state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic [BANK_W-1:0]  wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               frame_err_q, frame_err_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  logic               take_word, rd_inc, wr_clr, rd_clr;
  logic [BANK_W-1:0]  wcnt_bank, rcnt_bank;
  logic [ADDR_W-1:0]  wcnt_addr, rcnt_addr;
  logic               wcnt_last, rcnt_last;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_bank_d   = '0;
    wr_addr_d   = '0;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
    phase_d     = phase_q;
    take_word   = 1'b0;
    rd_inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          frame_err_d = 1'b0;
        end
      end
      ST_ARMED: begin
        take_word = in_valid && frame_start;
      end
      ST_CAPTURE: begin
        take_word = in_valid;
        if (in_valid && frame_start && (phase_q != '0)) begin
          frame_err_d = 1'b1;
        end
      end
      ST_READOUT: begin
        rd_valid_d = 1'b1;
        if (rd_ready) begin
          rd_inc = 1'b1;
          if (rcnt_last) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The final write and the first read request go out in the same cycle.
    if (take_word) begin
      wr_en_d    = 1'b1;
      wr_bank_d  = wcnt_bank;
      wr_addr_d  = wcnt_addr;
      phase_d    = (phase_q == PHASE_MAX) ? '0 : phase_q + PHASE_ONE;
      state_d    = wcnt_last ? ST_READOUT : ST_CAPTURE;
      rd_valid_d = wcnt_last;
    end

    if (abort) begin
      state_d     = ST_IDLE;
      wr_en_d     = 1'b0;
      wr_bank_d   = '0;
      wr_addr_d   = '0;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;
      frame_err_d = frame_err_q;
      take_word   = 1'b0;
      rd_inc      = 1'b0;
    end

    if (state_d != ST_CAPTURE) begin
      phase_d = '0;
    end
  end

  // Counters sit at zero whenever their phase is not active, so entry always starts at b0:a0.
  assign wr_clr = (state_d != ST_CAPTURE);
  assign rd_clr = (state_d != ST_READOUT);

  bank_addr_counter #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH)
  ) u_wr_cnt (
    .clk_in(clk_in),
    .rst   (rst),
    .clr   (wr_clr),
    .inc   (take_word),
    .bank  (wcnt_bank),
    .addr  (wcnt_addr),
    .last  (wcnt_last)
  );

  bank_addr_counter #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_DEPTH(BANK_DEPTH)
  ) u_rd_cnt (
    .clk_in(clk_in),
    .rst   (rst),
    .clr   (rd_clr),
    .inc   (rd_inc),
    .bank  (rcnt_bank),
    .addr  (rcnt_addr),
    .last  (rcnt_last)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      phase_q     <= phase_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_bank   = rcnt_bank;
  assign rd_addr   = rcnt_addr;
  assign rd_last   = rd_valid_q && rcnt_last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule
